// File: rtl/id_exe_alu_unit_pkg.sv
// Shared constants for the ID/EXE slice: opcodes, functs, ALU codes and the
// bit layout of the ID/EXE pipeline register.
package id_exe_alu_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

  localparam logic [3:0] ALUC_AND = 4'b0000;
  localparam logic [3:0] ALUC_OR  = 4'b0001;
  localparam logic [3:0] ALUC_ADD = 4'b0010;
  localparam logic [3:0] ALUC_SUB = 4'b0110;
  localparam logic [3:0] ALUC_SLT = 4'b0111;
  localparam logic [3:0] ALUC_NOR = 4'b1100;

  // id_exe = {wreg, m2reg, wmem, aluc, aluimm, rn, qa, qb, imm_ext}
  localparam int IE_WIDTH    = 109;
  localparam int IE_IMM_LSB  = 0;
  localparam int IE_QB_LSB   = 32;
  localparam int IE_QA_LSB   = 64;
  localparam int IE_RN_LSB   = 96;
  localparam int IE_ALUIMM   = 101;
  localparam int IE_ALUC_LSB = 102;
  localparam int IE_WMEM     = 106;
  localparam int IE_M2REG    = 107;
  localparam int IE_WREG     = 108;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic [3:0] aluc;
    logic       aluimm;
    logic       regrt;
  } ctrl_t;

endpackage

// File: rtl/id_exe_alu_unit_alu_core.sv
// Purely combinational 32-bit ALU used in the EXE stage.
module alu_core
  import id_exe_alu_unit_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  aluc,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = '0;
    case (aluc)
      ALUC_AND: result = a & b;
      ALUC_OR:  result = a | b;
      ALUC_ADD: result = a + b;
      ALUC_SUB: result = a - b;
      ALUC_SLT: result = {31'd0, ($signed(a) < $signed(b))};
      ALUC_NOR: result = ~(a | b);
      default:  result = '0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/id_exe_alu_unit.sv
// Decode stage, ID/EXE pipeline register and EXE-stage ALU of the
// five-stage pipeline.
module id_exe_alu_unit
  import id_exe_alu_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic [31:0]         qa,
  input  logic [31:0]         qb,
  output logic [IE_WIDTH-1:0] id_exe,
  output logic                ewreg,
  output logic                em2reg,
  output logic                ewmem,
  output logic [4:0]          ern,
  output logic [31:0]         eqb,
  output logic [31:0]         alu_out,
  output logic                zero
);

  logic [5:0]          op;
  logic [5:0]          funct;
  logic [4:0]          rt;
  logic [4:0]          rd;
  logic [31:0]         imm_ext;
  logic [4:0]          rn;
  ctrl_t               ctrl;
  logic [IE_WIDTH-1:0] id_exe_d;

  assign op      = instr[31:26];
  assign funct   = instr[5:0];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign imm_ext = {{16{instr[15]}}, instr[15:0]};

  // Unrecognised opcodes and functs fall through as NOPs with all controls low.
  always_comb begin
    ctrl = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FUNCT_ADD: begin ctrl.wreg = 1'b1; ctrl.aluc = ALUC_ADD; end
          FUNCT_SUB: begin ctrl.wreg = 1'b1; ctrl.aluc = ALUC_SUB; end
          FUNCT_AND: begin ctrl.wreg = 1'b1; ctrl.aluc = ALUC_AND; end
          FUNCT_OR:  begin ctrl.wreg = 1'b1; ctrl.aluc = ALUC_OR;  end
          FUNCT_SLT: begin ctrl.wreg = 1'b1; ctrl.aluc = ALUC_SLT; end
          FUNCT_NOR: begin ctrl.wreg = 1'b1; ctrl.aluc = ALUC_NOR; end
          default:   ctrl = '0;
        endcase
      end
      OP_LW: begin
        ctrl.wreg   = 1'b1;
        ctrl.m2reg  = 1'b1;
        ctrl.aluc   = ALUC_ADD;
        ctrl.aluimm = 1'b1;
        ctrl.regrt  = 1'b1;
      end
      OP_SW: begin
        ctrl.wmem   = 1'b1;
        ctrl.aluc   = ALUC_ADD;
        ctrl.aluimm = 1'b1;
        ctrl.regrt  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign rn       = ctrl.regrt ? rt : rd;
  assign id_exe_d = {ctrl.wreg, ctrl.m2reg, ctrl.wmem, ctrl.aluc, ctrl.aluimm,
                     rn, qa, qb, imm_ext};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) id_exe <= '0;
    else        id_exe <= id_exe_d;
  end

  logic [31:0] eqa;
  logic [31:0] eimm;
  logic [3:0]  ealuc;
  logic        ealuimm;
  logic [31:0] alu_b;

  assign ewreg   = id_exe[IE_WREG];
  assign em2reg  = id_exe[IE_M2REG];
  assign ewmem   = id_exe[IE_WMEM];
  assign ealuc   = id_exe[IE_ALUC_LSB +: 4];
  assign ealuimm = id_exe[IE_ALUIMM];
  assign ern     = id_exe[IE_RN_LSB +: 5];
  assign eqa     = id_exe[IE_QA_LSB +: 32];
  assign eqb     = id_exe[IE_QB_LSB +: 32];
  assign eimm    = id_exe[IE_IMM_LSB +: 32];
  assign alu_b   = ealuimm ? eimm : eqb;

  alu_core u_alu (
    .a      (eqa),
    .b      (alu_b),
    .aluc   (ealuc),
    .result (alu_out),
    .zero   (zero)
  );

endmodule

// File: tb/tb_id_exe_alu_unit.sv
// Scoreboard bench for id_exe_alu_unit: directed test-plan cases, random
// instructions and an asynchronous reset pulse, checked against a behavioural model.
module tb_id_exe_alu_unit;

  logic         clk;
  logic         rst_n;
  logic [31:0]  instr;
  logic [31:0]  qa;
  logic [31:0]  qb;
  logic [108:0] id_exe;
  logic         ewreg;
  logic         em2reg;
  logic         ewmem;
  logic [4:0]   ern;
  logic [31:0]  eqb;
  logic [31:0]  alu_out;
  logic         zero;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    string        name;
    int           cap;
    logic [108:0] id_exe;
    logic         wreg;
    logic         m2reg;
    logic         wmem;
    logic [4:0]   rn;
    logic [31:0]  eqb;
    logic [31:0]  alu;
    logic         zero;
  } exp_t;

  exp_t sb[$];

  id_exe_alu_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .instr   (instr),
    .qa      (qa),
    .qb      (qb),
    .id_exe  (id_exe),
    .ewreg   (ewreg),
    .em2reg  (em2reg),
    .ewmem   (ewmem),
    .ern     (ern),
    .eqb     (eqb),
    .alu_out (alu_out),
    .zero    (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference: what each instruction means, written from the ISA rules.
  function automatic exp_t model(input string name, input logic [31:0] ins,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t               e;
    logic [5:0]         op     = ins[31:26];
    logic [5:0]         fn     = ins[5:0];
    logic signed [15:0] simm   = ins[15:0];
    logic signed [31:0] sx     = simm;
    logic [3:0]         aluc   = 4'd0;
    logic               aluimm = 1'b0;
    e.name  = name;
    e.cap   = 0;
    e.wreg  = 1'b0;
    e.m2reg = 1'b0;
    e.wmem  = 1'b0;
    e.rn    = ins[15:11];
    e.alu   = a & b;
    if (op == 6'd0) begin
      e.wreg = 1'b1;
      if      (fn == 6'h20) begin aluc = 4'd2;  e.alu = a + b; end
      else if (fn == 6'h22) begin aluc = 4'd6;  e.alu = a - b; end
      else if (fn == 6'h24) begin aluc = 4'd0;  e.alu = a & b; end
      else if (fn == 6'h25) begin aluc = 4'd1;  e.alu = a | b; end
      else if (fn == 6'h2A) begin aluc = 4'd7;  e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
      else if (fn == 6'h27) begin aluc = 4'd12; e.alu = ~(a | b); end
      else e.wreg = 1'b0;
    end else if (op == 6'h23 || op == 6'h2B) begin
      e.wreg  = (op == 6'h23);
      e.m2reg = (op == 6'h23);
      e.wmem  = (op == 6'h2B);
      e.rn    = ins[20:16];
      aluc    = 4'd2;
      aluimm  = 1'b1;
      e.alu   = a + sx;
    end
    e.eqb    = b;
    e.zero   = (e.alu == 32'd0);
    e.id_exe = {e.wreg, e.m2reg, e.wmem, aluc, aluimm, e.rn, a, b, sx};
    return e;
  endfunction

  task automatic check_output(input string name, input logic [108:0] actual,
                              input logic [108:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input string name, input logic [31:0] ins,
                                input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    instr = ins;
    qa    = a;
    qb    = b;
    e     = model(name, ins, a, b);
    e.cap = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic check_reset(input string name);
    check_output({name, "/id_exe"}, id_exe, '0);
    check_output({name, "/ctl"}, {ewreg, em2reg, ewmem, ern}, '0);
    check_output({name, "/eqb"}, eqb, '0);
    check_output({name, "/alu_out"}, alu_out, '0);
    check_output({name, "/zero"}, zero, 1);
  endtask

  // Monitor: every cycle the registered result is compared to the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && sb.size() > 0) begin
      if (sb[0].cap < cyc) begin
        e = sb.pop_front();
        check_output({e.name, "/stale"}, cyc, e.cap);
      end else if (sb[0].cap == cyc) begin
        e = sb.pop_front();
        check_output({e.name, "/id_exe"}, id_exe, e.id_exe);
        check_output({e.name, "/ewreg"}, ewreg, e.wreg);
        check_output({e.name, "/em2reg"}, em2reg, e.m2reg);
        check_output({e.name, "/ewmem"}, ewmem, e.wmem);
        check_output({e.name, "/ern"}, ern, e.rn);
        check_output({e.name, "/eqb"}, eqb, e.eqb);
        check_output({e.name, "/alu_out"}, alu_out, e.alu);
        check_output({e.name, "/zero"}, zero, e.zero);
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [5:0] functs [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h3F};
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 3))
      0:       r = {6'h00, r[25:6], functs[$urandom_range(0, 6)]};
      1:       r = {6'h23, r[25:0]};
      2:       r = {6'h2B, r[25:0]};
      default: r = r;
    endcase
    return r;
  endfunction

  initial begin
    rst_n = 1'b0;
    instr = $urandom;
    qa    = $urandom;
    qb    = $urandom;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    apply_stimulus("add", 32'h00221820, 32'd5, 32'd7);
    apply_stimulus("and", 32'h00221824, 32'h0000000F, 32'h000000F0);
    apply_stimulus("or",  32'h00221825, 32'h0000000F, 32'h000000F0);
    apply_stimulus("sub", 32'h00221822, 32'h0000000F, 32'h000000F0);
    apply_stimulus("nor", 32'h00221827, 32'h0000000F, 32'h000000F0);
    apply_stimulus("slt", 32'h0022182A, 32'hFFFFFFFF, 32'h00000001);
    apply_stimulus("lw",  32'h8C22FFFC, 32'd100, $urandom);
    apply_stimulus("sw",  32'hAC220008, 32'd100, 32'hDEADBEEF);
    apply_stimulus("bad_op",    32'hFC000000, $urandom, $urandom);
    apply_stimulus("bad_funct", 32'h0000003F, $urandom, $urandom);

    for (int i = 0; i < 80; i++)
      apply_stimulus("rand", rand_instr(), $urandom, $urandom);

    // Reset pulse between edges: outputs clear at once, held sw is captured after release.
    apply_stimulus("add2", 32'h00221820, $urandom, $urandom);
    apply_stimulus("lw2",  32'h8C22FFFC, $urandom, $urandom);
    apply_stimulus("sw2",  32'hAC220008, $urandom, $urandom);
    #2 rst_n = 1'b0;
    #1 check_reset("mid_reset");
    #1 rst_n = 1'b1;
    apply_stimulus("add3", 32'h00221820, 32'd1, 32'hFFFFFFFF);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    check_output("drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
